// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator. All channels share one prescaler and one period counter.
// Duty and mode changes are double-buffered and take effect only at a period boundary.
module pwm_multichannel #(
  parameter int CHANNELS        = 4,
  parameter int RESOLUTION_BITS = 8,
  parameter int PRESCALE_BITS   = 3,
  localparam int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       center_mode,
  input  logic                       wr_en,
  input  logic [CH_W-1:0]            wr_ch,
  input  logic [RESOLUTION_BITS-1:0] wr_duty,
  output logic [CHANNELS-1:0]        pwm_out,
  output logic [RESOLUTION_BITS-1:0] cnt_value,
  output logic                       period_start,
  output logic                       mode_active
);

  localparam logic [RESOLUTION_BITS-1:0] MAX = '1;
  localparam logic [RESOLUTION_BITS-1:0] ONE = RESOLUTION_BITS'(1);

  logic [PRESCALE_BITS-1:0]   r_pre_cnt;
  logic [RESOLUTION_BITS-1:0] r_cnt;
  logic                       r_dir_down;
  logic                       r_mode_active;
  logic                       r_period_start;
  logic [CHANNELS-1:0]        r_pwm;
  logic [RESOLUTION_BITS-1:0] r_shadow [CHANNELS];
  logic [RESOLUTION_BITS-1:0] r_active [CHANNELS];

  logic                       w_tick;
  logic                       w_boundary;
  logic                       w_mode_switch;
  logic [RESOLUTION_BITS-1:0] w_cnt_next;
  logic                       w_dir_next;

  assign w_tick        = &r_pre_cnt;
  assign w_boundary    = w_tick && (r_mode_active ? (r_dir_down && (r_cnt == ONE))
                                                  : (r_cnt == MAX));
  assign w_mode_switch = w_boundary && (center_mode != r_mode_active);

  // Next counter value and direction; only consumed on a prescaler tick.
  always_comb begin
    w_cnt_next = r_cnt;
    w_dir_next = r_dir_down;
    if (w_mode_switch) begin
      w_cnt_next = '0;
      w_dir_next = 1'b0;
    end else if (!r_mode_active) begin
      w_cnt_next = r_cnt + ONE;
      w_dir_next = 1'b0;
    end else if (!r_dir_down) begin
      if (r_cnt == MAX) begin
        w_cnt_next = MAX - ONE;
        w_dir_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + ONE;
      end
    end else begin
      if (r_cnt == '0) begin
        w_cnt_next = ONE;
        w_dir_next = 1'b0;
      end else begin
        w_cnt_next = r_cnt - ONE;
        // Reaching 0 on the way down starts the next up-count.
        if (r_cnt == ONE) w_dir_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt      <= '0;
      r_cnt          <= '0;
      r_dir_down     <= 1'b0;
      r_mode_active  <= 1'b0;
      r_period_start <= 1'b0;
    end else begin
      r_pre_cnt      <= r_pre_cnt + PRESCALE_BITS'(1);
      r_period_start <= w_boundary;
      if (w_tick) begin
        r_cnt      <= w_cnt_next;
        r_dir_down <= w_dir_next;
      end
      if (w_boundary) r_mode_active <= center_mode;
    end
  end

  // Shadow writes to a nonexistent channel match no index and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_en && (wr_ch == CH_W'(i))) r_shadow[i] <= wr_duty;
        if (w_boundary) r_active[i] <= r_shadow[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pwm[i] <= (r_cnt < r_active[i]);
      end
    end
  end

  assign pwm_out      = r_pwm;
  assign cnt_value    = r_cnt;
  assign period_start = r_period_start;
  assign mode_active  = r_mode_active;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: a default 4-channel instance and a
// 3-channel instance with a 2-clock prescaler.
module tb_pwm_multichannel;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: 4 channels, 8-bit, prescale 8
  logic       rst = 1'b1;
  logic       center_mode = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = '0;
  logic [7:0] wr_duty = '0;
  logic [3:0] pwm_out;
  logic [7:0] cnt_value;
  logic       period_start;
  logic       mode_active;

  pwm_multichannel #(.CHANNELS(4), .RESOLUTION_BITS(8), .PRESCALE_BITS(3)) u_dut (
    .clk(clk), .rst(rst), .center_mode(center_mode), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .pwm_out(pwm_out), .cnt_value(cnt_value),
    .period_start(period_start), .mode_active(mode_active)
  );

  // Instance 2: 3 channels, 8-bit, prescale 2
  logic       rst2 = 1'b1;
  logic       center2 = 1'b0;
  logic       wr_en2 = 1'b0;
  logic [1:0] wr_ch2 = '0;
  logic [7:0] wr_duty2 = '0;
  logic [2:0] pwm2;
  logic [7:0] cnt2;
  logic       ps2;
  logic       mode2;

  pwm_multichannel #(.CHANNELS(3), .RESOLUTION_BITS(8), .PRESCALE_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst2), .center_mode(center2), .wr_en(wr_en2), .wr_ch(wr_ch2),
    .wr_duty(wr_duty2), .pwm_out(pwm2), .cnt_value(cnt2),
    .period_start(ps2), .mode_active(mode2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int hi_cnt [4];
  int ps_pos;
  int cnt_max;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic write1(input logic [1:0] ch, input logic [7:0] duty);
    wr_ch   = ch;
    wr_duty = duty;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic write2(input logic [1:0] ch, input logic [7:0] duty);
    wr_ch2   = ch;
    wr_duty2 = duty;
    wr_en2   = 1'b1;
    @(negedge clk);
    wr_en2   = 1'b0;
  endtask

  task automatic wait_ps1(input int budget, input string tag);
    logic found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (period_start) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  // Samples n clocks of instance 1, optionally issuing one write at sample wr_at.
  task automatic window1(input int n, input int wr_at, input logic [1:0] ch, input logic [7:0] duty);
    for (int i = 0; i < 4; i++) hi_cnt[i] = 0;
    ps_pos  = 0;
    cnt_max = 0;
    for (int s = 1; s <= n; s++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) hi_cnt[i] += int'(pwm_out[i]);
      if (period_start && ps_pos == 0) ps_pos = s;
      if (int'(cnt_value) > cnt_max) cnt_max = int'(cnt_value);
      if (s == wr_at) begin
        wr_ch   = ch;
        wr_duty = duty;
        wr_en   = 1'b1;
      end else begin
        wr_en   = 1'b0;
      end
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    int   h2 [3];
    int   p2;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cnt", cnt_value, 0);
    check("rst_mode", mode_active, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_ps", period_start, 0);

    // Edge mode duties
    write1(2'd0, 8'd64);
    write1(2'd1, 8'd0);
    write1(2'd2, 8'd255);
    write1(2'd3, 8'd128);
    check("pre_boundary_pwm", pwm_out, 0);
    wait_ps1(3000, "first_boundary");
    check("bnd_cnt", cnt_value, 0);
    check("bnd_mode", mode_active, 0);

    // Mid-period write of ch0=200 must not disturb this period
    window1(2048, 1000, 2'd0, 8'd200);
    check("edge_ch0", hi_cnt[0], 512);
    check("edge_ch1", hi_cnt[1], 0);
    check("edge_ch2", hi_cnt[2], 2040);
    check("edge_ch3", hi_cnt[3], 1024);
    check("edge_period", ps_pos, 2048);
    check("edge_cnt_max", cnt_max, 255);

    // Write in the boundary clock (sample 2047) is deferred one period
    window1(2048, 2047, 2'd0, 8'd32);
    check("upd_ch0_200", hi_cnt[0], 1600);
    check("upd_period", ps_pos, 2048);

    window1(2048, 0, 2'd0, 8'd0);
    check("late_write_ch0", hi_cnt[0], 1600);

    // Request center mode; it applies at the end of this period
    center_mode = 1'b1;
    window1(2048, 500, 2'd0, 8'd64);
    check("late_write_applied", hi_cnt[0], 256);
    check("switch_mode", mode_active, 1);
    check("switch_cnt", cnt_value, 0);

    // Center mode: 510 ticks per period, values 0..255..1
    window1(4080, 0, 2'd0, 8'd0);
    check("ctr_ch0", hi_cnt[0], 1016);
    check("ctr_ch1", hi_cnt[1], 0);
    check("ctr_ch2", hi_cnt[2], 4072);
    check("ctr_ch3", hi_cnt[3], 2040);
    check("ctr_period", ps_pos, 4080);
    check("ctr_cnt_max", cnt_max, 255);
    check("ctr_mode", mode_active, 1);

    // Reset mid-period at cnt=100
    found = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (cnt_value == 8'd100) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_cnt100", found, 1);
    center_mode = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_cnt", cnt_value, 0);
    check("mid_rst_mode", mode_active, 0);
    check("mid_rst_pwm", pwm_out, 0);
    check("mid_rst_ps", period_start, 0);
    window1(2100, 0, 2'd0, 8'd0);
    check("post_rst_ch0", hi_cnt[0], 0);
    check("post_rst_ch2", hi_cnt[2], 0);
    check("post_rst_ch3", hi_cnt[3], 0);
    check("post_rst_period", ps_pos, 2048);

    // Instance 2: invalid channel write and prescale-2 latency
    @(negedge clk);
    rst2 = 1'b0;
    check("i2_rst_cnt", cnt2, 0);
    write2(2'd0, 8'd64);
    write2(2'd1, 8'd128);
    write2(2'd2, 8'd200);
    write2(2'd3, 8'd50);
    check("i2_pre_pwm", pwm2, 0);
    found = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (ps2) begin
        found = 1'b1;
        break;
      end
    end
    check("i2_boundary", found, 1);
    for (int i = 0; i < 3; i++) h2[i] = 0;
    p2 = 0;
    for (int s = 1; s <= 512; s++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) h2[i] += int'(pwm2[i]);
      if (ps2 && p2 == 0) p2 = s;
      if (s == 1)   check("i2_cnt_s1", cnt2, 0);
      if (s == 10)  check("i2_cnt_s10", cnt2, 5);
      if (s == 128) check("i2_cross_cnt", cnt2, 64);
      if (s == 128) check("i2_cross_pwm_hi", pwm2[0], 1);
      if (s == 129) check("i2_cross_pwm_lo", pwm2[0], 0);
    end
    check("i2_ch0", h2[0], 128);
    check("i2_ch1", h2[1], 256);
    check("i2_ch2", h2[2], 400);
    check("i2_period", p2, 512);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
